// File: rtl/spi_frame_rx.sv
// spi_frame_rx
//   SPI slave frame receiver. Oversamples sck/sdi/load in the i_clk domain and
//   assembles one FRAME_BITS-wide frame per load window, MSB first, in any SPI
//   mode. A frame is handed downstream over a valid/ready handshake. Dropped
//   frames raise o_overrun, and frames cut short by load raise o_abort_err.
//
//   Optional feature macro: SPI_RX_ECHO_EN
//     When defined, the previously delivered frame is echoed on o_sdo, MSB
//     first. When undefined, o_sdo is tied low and no tx register is built.
//
// Parameters
//   FRAME_BITS     bits per frame (8..1024)
//   MODE           SPI mode 0..3 (CPOL = MODE[1], CPHA = MODE[0])
// Ports
//   i_clk          system clock, at least 8x the sck frequency
//   i_reset_n      asynchronous active-low reset
//   i_sck          SPI clock from the master (asynchronous)
//   i_sdi          MOSI (asynchronous)
//   i_load         active-high chip select, one frame per high window
//   o_sdo          MISO
//   o_frame_data   last delivered frame, first received bit at MSB
//   o_frame_valid  o_frame_data holds an unconsumed frame
//   i_frame_ready  consumer accepts when valid and ready are both high
//   o_overrun      one-cycle pulse: a completed frame was dropped
//   o_abort_err    one-cycle pulse: load fell mid-frame
//
// state  | meaning
// -------+--------------------------------------------------------------
// IDLE   | load low, bit counter held at 0
// ACTIVE | receiving; each sample edge shifts sdi in and bumps the counter
// DONE   | FRAME_BITS received; sck ignored until load falls

module spi_frame_rx #(
  parameter int FRAME_BITS = 128,
  parameter int MODE       = 0
) (
  input  logic                  i_clk,
  input  logic                  i_reset_n,
  input  logic                  i_sck,
  input  logic                  i_sdi,
  input  logic                  i_load,
  output logic                  o_sdo,
  output logic [FRAME_BITS-1:0] o_frame_data,
  output logic                  o_frame_valid,
  input  logic                  i_frame_ready,
  output logic                  o_overrun,
  output logic                  o_abort_err
);

  localparam int CNT_W = $clog2(FRAME_BITS + 1);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(FRAME_BITS - 1);
  localparam bit CPOL = ((MODE / 2) % 2) == 1;
  localparam bit CPHA = (MODE % 2) == 1;
  // Modes 0 and 3 sample on the rising sck edge, modes 1 and 2 on the falling.
  localparam bit SAMPLE_ON_RISE = (CPOL == CPHA);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] ACTIVE = 2'd1;
  localparam logic [1:0] DONE   = 2'd2;

  logic [2:0]            r_sck_s;
  logic [2:0]            r_load_s;
  logic [1:0]            r_sdi_s;
  logic [1:0]            r_state;
  logic [CNT_W-1:0]      r_cnt;
  logic [FRAME_BITS-1:0] r_rx;
  logic [FRAME_BITS-1:0] r_frame_data;
  logic                  r_frame_valid;
  logic                  r_overrun;
  logic                  r_abort_err;

  logic                  w_sck_rise;
  logic                  w_sck_fall;
  logic                  w_sample;
  logic                  w_shift;
  logic                  w_load_rise;
  logic                  w_load_fall;
  logic                  w_complete;
  logic                  w_accept;
  logic [FRAME_BITS-1:0] w_rx_next;

  // Bits [1] are the synchronised values; bit [2] of sck/load is the
  // previous synchronised value used for edge detection.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_sck_s  <= '0;
      r_load_s <= '0;
      r_sdi_s  <= '0;
    end else begin
      r_sck_s  <= {r_sck_s[1:0], i_sck};
      r_load_s <= {r_load_s[1:0], i_load};
      r_sdi_s  <= {r_sdi_s[0], i_sdi};
    end
  end

  assign w_sck_rise  =  r_sck_s[1] & ~r_sck_s[2];
  assign w_sck_fall  = ~r_sck_s[1] &  r_sck_s[2];
  assign w_load_rise =  r_load_s[1] & ~r_load_s[2];
  assign w_load_fall = ~r_load_s[1] &  r_load_s[2];
  assign w_sample    = SAMPLE_ON_RISE ? w_sck_rise : w_sck_fall;
  assign w_shift     = SAMPLE_ON_RISE ? w_sck_fall : w_sck_rise;

  assign w_rx_next  = {r_rx[FRAME_BITS-2:0], r_sdi_s[1]};
  // load falling wins over a coincident sample edge: the frame is abandoned.
  assign w_complete = (r_state == ACTIVE) && !w_load_fall && w_sample &&
                      (r_cnt == LAST_BIT);
  assign w_accept   = r_frame_valid & i_frame_ready;

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_rx    <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          r_cnt <= '0;
          if (w_load_rise) begin
            r_state <= ACTIVE;
            r_rx    <= '0;
          end
        end
        ACTIVE: begin
          if (w_load_fall) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_rx    <= '0;
          end else if (w_sample) begin
            r_rx  <= w_rx_next;
            r_cnt <= r_cnt + 1'b1;
            if (r_cnt == LAST_BIT) begin
              r_state <= DONE;
            end
          end
        end
        DONE: begin
          if (w_load_fall) begin
            r_state <= IDLE;
            r_cnt   <= '0;
          end
        end
        default: begin
          r_state <= IDLE;
          r_cnt   <= '0;
        end
      endcase
    end
  end

  // A completing frame may replace a pending one only if the consumer takes
  // the pending one in the same cycle; otherwise the new frame is dropped.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_frame_data  <= '0;
      r_frame_valid <= 1'b0;
      r_overrun     <= 1'b0;
      r_abort_err   <= 1'b0;
    end else begin
      r_overrun   <= 1'b0;
      r_abort_err <= (r_state == ACTIVE) && w_load_fall && (r_cnt != '0);
      if (w_complete && (!r_frame_valid || i_frame_ready)) begin
        r_frame_data  <= w_rx_next;
        r_frame_valid <= 1'b1;
      end else begin
        if (w_complete) begin
          r_overrun <= 1'b1;
        end
        if (w_accept) begin
          r_frame_valid <= 1'b0;
        end
      end
    end
  end

  assign o_frame_data  = r_frame_data;
  assign o_frame_valid = r_frame_valid;
  assign o_overrun     = r_overrun;
  assign o_abort_err   = r_abort_err;

`ifdef SPI_RX_ECHO_EN
  logic [FRAME_BITS-1:0] r_tx;

  // Shifts only while ACTIVE and after the first sample. This skips the
  // leading shift edge in CPHA=1 modes and the trailing one in CPHA=0 modes,
  // giving at most FRAME_BITS-1 shifts per frame.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_tx <= '0;
    end else if ((r_state == IDLE) && w_load_rise) begin
      r_tx <= r_frame_data;
    end else if ((r_state == ACTIVE) && w_shift && (r_cnt != '0)) begin
      r_tx <= {r_tx[FRAME_BITS-2:0], 1'b0};
    end
  end

  assign o_sdo = r_tx[FRAME_BITS-1] & (r_state != IDLE);
`else
  assign o_sdo = 1'b0;
`endif

endmodule
